// File: rtl/jtag_scan_master.sv
// Host-side JTAG scan engine: one valid/ready command in, one captured-TDO response out.
// Define JTAG_SCAN_IDLE_CLOCKS_EN to append RTI_CYCLES Run-Test/Idle TCKs after each scan and TAP reset.
module jtag_scan_master #(
  parameter int MAX_LEN    = 38,
  parameter int LEN_W      = 6,
  parameter int CLK_DIV    = 4,
  parameter int RTI_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               rsp_err,
  output logic               busy,
  output logic               tck,
  output logic               tms,
  output logic               tdi,
  input  logic               tdo
);

  localparam int PH_W = $clog2(CLK_DIV);
  localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(CLK_DIV - 1);
  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_TRST  = 3'd1;
  localparam logic [2:0] S_PRE   = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_POST  = 3'd4;
  localparam logic [2:0] S_RTI   = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  localparam logic [1:0] OP_IR   = 2'd1;
  localparam logic [1:0] OP_TRST = 2'd2;
  localparam logic [1:0] OP_RSVD = 2'd3;

  // Number of TCKs each TCK-issuing state spends before handing over.
  function automatic logic [LEN_W-1:0] seg_len(input logic [2:0] st, input logic [1:0] op,
                                               input logic [LEN_W-1:0] len);
    case (st)
      S_TRST:  seg_len = LEN_W'(6);
      S_PRE:   seg_len = (op == OP_IR) ? LEN_W'(4) : LEN_W'(3);
      S_SHIFT: seg_len = len;
      S_POST:  seg_len = LEN_W'(2);
      S_RTI:   seg_len = LEN_W'(RTI_CYCLES);
      default: seg_len = LEN_W'(1);
    endcase
  endfunction

  function automatic logic [2:0] seg_next(input logic [2:0] st);
    case (st)
      S_PRE:   seg_next = S_SHIFT;
      S_SHIFT: seg_next = S_POST;
`ifdef JTAG_SCAN_IDLE_CLOCKS_EN
      S_TRST, S_POST: seg_next = (RTI_CYCLES > 0) ? S_RTI : S_DONE;
`endif
      default: seg_next = S_DONE;
    endcase
  endfunction

  // TMS value presented for TCK number cnt within state st.
  function automatic logic tms_for(input logic [2:0] st, input logic [LEN_W-1:0] cnt,
                                   input logic [1:0] op, input logic [LEN_W-1:0] len);
    case (st)
      S_TRST:  tms_for = (cnt < LEN_W'(5));
      S_PRE:   tms_for = (op == OP_IR) ? (cnt < LEN_W'(2)) : (cnt == '0);
      S_SHIFT: tms_for = (cnt == len - 1'b1);
      S_POST:  tms_for = (cnt == '0);
      default: tms_for = 1'b0;
    endcase
  endfunction

  function automatic logic tdi_for(input logic [2:0] st, input logic [LEN_W-1:0] cnt,
                                   input logic [MAX_LEN-1:0] data);
    logic [MAX_LEN-1:0] sh;
    sh      = data >> cnt;
    tdi_for = (st == S_SHIFT) && sh[0];
  endfunction

  logic [2:0]         state_q, state_d;
  logic [PH_W-1:0]    ph_q, ph_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [MAX_LEN-1:0] data_q, data_d;
  logic [MAX_LEN-1:0] cap_q, cap_d;
  logic               tck_q, tck_d;
  logic               tms_q, tms_d;
  logic               tdi_q, tdi_d;
  logic [MAX_LEN-1:0] rsp_data_q, rsp_data_d;
  logic               rsp_err_q, rsp_err_d;

  logic               active, wrap, rise, fall, last_tck, bad_cmd;
  logic [2:0]         nxt_st, first_st;
  logic [LEN_W-1:0]   nxt_cnt;

  // TMS/TDI advance on the TCK fall that ends the current bit; TDO is taken on the TCK rise.
  always_comb begin
    state_d    = state_q;
    ph_d       = ph_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    len_d      = len_q;
    data_d     = data_q;
    cap_d      = cap_q;
    tck_d      = tck_q;
    tms_d      = tms_q;
    tdi_d      = tdi_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;

    active   = (state_q != S_IDLE) && (state_q != S_DONE);
    wrap     = active && (ph_q == PH_LAST);
    rise     = wrap && !tck_q;
    fall     = wrap && tck_q;
    last_tck = (cnt_q == seg_len(state_q, op_q, len_q) - 1'b1);
    nxt_st   = last_tck ? seg_next(state_q) : state_q;
    nxt_cnt  = last_tck ? '0 : cnt_q + 1'b1;
    bad_cmd  = (cmd_op == OP_RSVD) ||
               ((cmd_op != OP_TRST) && ((cmd_len == '0) || (cmd_len > MAX_LEN_L)));
    first_st = bad_cmd ? S_DONE : ((cmd_op == OP_TRST) ? S_TRST : S_PRE);

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          state_d = first_st;
          ph_d    = '0;
          cnt_d   = '0;
          op_d    = cmd_op;
          len_d   = cmd_len;
          data_d  = cmd_data;
          cap_d   = '0;
          tms_d   = tms_for(first_st, '0, cmd_op, cmd_len);
          tdi_d   = tdi_for(first_st, '0, cmd_data);
          if (bad_cmd) begin
            rsp_data_d = '0;
            rsp_err_d  = 1'b1;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: begin
        ph_d = wrap ? '0 : ph_q + 1'b1;
        if (wrap) tck_d = !tck_q;
        if (rise && (state_q == S_SHIFT)) cap_d = cap_q | (MAX_LEN'(tdo) << cnt_q);
        if (fall) begin
          state_d = nxt_st;
          cnt_d   = nxt_cnt;
          tms_d   = tms_for(nxt_st, nxt_cnt, op_q, len_q);
          tdi_d   = tdi_for(nxt_st, nxt_cnt, data_q);
          if (nxt_st == S_DONE) begin
            rsp_data_d = cap_q;
            rsp_err_d  = 1'b0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      ph_q       <= '0;
      cnt_q      <= '0;
      op_q       <= '0;
      len_q      <= '0;
      data_q     <= '0;
      cap_q      <= '0;
      tck_q      <= 1'b0;
      tms_q      <= 1'b1;
      tdi_q      <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ph_q       <= ph_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      len_q      <= len_d;
      data_q     <= data_d;
      cap_q      <= cap_d;
      tck_q      <= tck_d;
      tms_q      <= tms_d;
      tdi_q      <= tdi_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = (state_q == S_DONE);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign tck       = tck_q;
  assign tms       = tms_q;
  assign tdi       = tdi_q;

endmodule

// File: tb/tb_jtag_scan_master.sv
// Bench for jtag_scan_master: a TAP model on the pins plus a per-TCK expectation stream.
// Honours JTAG_SCAN_IDLE_CLOCKS_EN the same way as the design.
`timescale 1ns/1ps
module tb_jtag_scan_master;
  localparam int MAX_LEN    = 38;
  localparam int LEN_W      = 6;
  localparam int CLK_DIV    = 4;
  localparam int RTI_CYCLES = 2;
`ifdef JTAG_SCAN_IDLE_CLOCKS_EN
  localparam int RTI_EXTRA = RTI_CYCLES;
`else
  localparam int RTI_EXTRA = 0;
`endif
  localparam logic [37:0] DR_PRELOAD = 38'h2A_5A5A_A5A5;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic [1:0]         cmd_op = 2'd0;
  logic [LEN_W-1:0]   cmd_len = '0;
  logic [MAX_LEN-1:0] cmd_data = '0;
  logic               rsp_valid;
  logic [MAX_LEN-1:0] rsp_data;
  logic               rsp_err;
  logic               busy;
  logic               tck, tms, tdi;
  logic               tdo = 1'b0;

  always #5 clk = ~clk;

  jtag_scan_master #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CLK_DIV(CLK_DIV), .RTI_CYCLES(RTI_CYCLES)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy), .tck(tck), .tms(tms),
    .tdi(tdi), .tdo(tdo)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // IEEE 1149.1 TAP controller with a 38-bit DR and a 2-bit IR (capture value 2'b01)
  typedef enum logic [3:0] {T_TLR, T_RTI, T_SELDR, T_CAPDR, T_SHDR, T_EX1DR, T_PADR, T_EX2DR,
                            T_UPDR, T_SELIR, T_CAPIR, T_SHIR, T_EX1IR, T_PAIR, T_EX2IR, T_UPIR} tap_t;
  tap_t        tap_st = T_TLR;
  logic [37:0] dr_sr = '0, dr_upd = '0;
  logic [1:0]  ir_sr = '0, ir_upd = '0;

  always @(posedge tck) begin
    case (tap_st)
      T_CAPDR: dr_sr = DR_PRELOAD;
      T_SHDR:  dr_sr = {tdi, dr_sr[37:1]};
      T_UPDR:  dr_upd = dr_sr;
      T_CAPIR: ir_sr = 2'b01;
      T_SHIR:  ir_sr = {tdi, ir_sr[1]};
      T_UPIR:  ir_upd = ir_sr;
      default: ;
    endcase
    case (tap_st)
      T_TLR:   tap_st = tms ? T_TLR   : T_RTI;
      T_RTI:   tap_st = tms ? T_SELDR : T_RTI;
      T_SELDR: tap_st = tms ? T_SELIR : T_CAPDR;
      T_CAPDR: tap_st = tms ? T_EX1DR : T_SHDR;
      T_SHDR:  tap_st = tms ? T_EX1DR : T_SHDR;
      T_EX1DR: tap_st = tms ? T_UPDR  : T_PADR;
      T_PADR:  tap_st = tms ? T_EX2DR : T_PADR;
      T_EX2DR: tap_st = tms ? T_UPDR  : T_SHDR;
      T_UPDR:  tap_st = tms ? T_SELDR : T_RTI;
      T_SELIR: tap_st = tms ? T_TLR   : T_CAPIR;
      T_CAPIR: tap_st = tms ? T_EX1IR : T_SHIR;
      T_SHIR:  tap_st = tms ? T_EX1IR : T_SHIR;
      T_EX1IR: tap_st = tms ? T_UPIR  : T_PAIR;
      T_PAIR:  tap_st = tms ? T_EX2IR : T_PAIR;
      T_EX2IR: tap_st = tms ? T_UPIR  : T_SHIR;
      default: tap_st = tms ? T_SELDR : T_RTI;
    endcase
  end

  always @(negedge tck)
    tdo = (tap_st == T_SHDR) ? dr_sr[0] : ((tap_st == T_SHIR) ? ir_sr[0] : 1'b0);

  // Expected pin activity per TCK rise, and expected response per command
  typedef struct { logic tms; logic chk_tdi; logic tdi; } tck_exp_t;
  typedef struct { logic [37:0] data; logic err; int ntck; } rsp_exp_t;
  tck_exp_t exp_tck_q[$];
  rsp_exp_t exp_rsp_q[$];

  task automatic push_tck(input logic t, input logic chk, input logic d, inout int n);
    tck_exp_t e;
    e.tms = t; e.chk_tdi = chk; e.tdi = d;
    exp_tck_q.push_back(e);
    n++;
  endtask

  task automatic expect_cmd(input logic [1:0] op, input int len, input logic [37:0] data);
    rsp_exp_t    r;
    int          n;
    logic [37:0] mask;
    n = 0; r.data = '0; r.err = 1'b0;
    mask = (38'd1 << len) - 38'd1;
    if (op == 2'd3 || (op != 2'd2 && (len == 0 || len > MAX_LEN))) begin
      r.err = 1'b1;
    end else if (op == 2'd2) begin
      for (int i = 0; i < 6; i++) push_tck(i < 5, 1'b0, 1'b0, n);
      for (int i = 0; i < RTI_EXTRA; i++) push_tck(1'b0, 1'b0, 1'b0, n);
    end else begin
      push_tck(1'b1, 1'b0, 1'b0, n);
      if (op == 2'd1) push_tck(1'b1, 1'b0, 1'b0, n);
      push_tck(1'b0, 1'b0, 1'b0, n);
      push_tck(1'b0, 1'b0, 1'b0, n);
      for (int i = 0; i < len; i++) push_tck(i == len - 1, 1'b1, data[i], n);
      push_tck(1'b1, 1'b0, 1'b0, n);
      push_tck(1'b0, 1'b0, 1'b0, n);
      for (int i = 0; i < RTI_EXTRA; i++) push_tck(1'b0, 1'b0, 1'b0, n);
      r.data = (op == 2'd0) ? (DR_PRELOAD & mask) : (38'b01 & mask);
    end
    r.ntck = n;
    exp_rsp_q.push_back(r);
  endtask

  // Compare process: sampled on the falling clk edge, away from DUT updates
  int          rises = 0;
  int          total_rises = 0;
  int          rsp_count = 0;
  int          last_ntck = 0;
  logic [37:0] last_rsp = '0;
  logic        last_err = 1'b0;
  logic        prev_tck = 1'b0;

  always @(negedge clk) begin
    tck_exp_t e;
    rsp_exp_t r;
    if (!reset_n) begin
      rises = 0;
    end else begin
      if (tck && !prev_tck) begin
        rises++;
        total_rises++;
        if (exp_tck_q.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL extra_tck: got a TCK rise, expected none");
        end else begin
          e = exp_tck_q.pop_front();
          check_output("tms_at_rise", tms, e.tms);
          if (e.chk_tdi) check_output("tdi_at_rise", tdi, e.tdi);
        end
      end
      check_output("ready_vs_busy", cmd_ready, !busy);
      check_output("tck_only_busy", tck & !busy, 1'b0);
      if (rsp_valid) begin
        last_rsp  = rsp_data;
        last_err  = rsp_err;
        last_ntck = rises;
        rsp_count++;
        if (exp_rsp_q.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL unexpected_rsp: got rsp_valid, expected none");
        end else begin
          r = exp_rsp_q.pop_front();
          check_output("rsp_data", rsp_data, r.data);
          check_output("rsp_err", rsp_err, r.err);
          check_output("tck_count", rises, r.ntck);
        end
        check_output("done_tck", tck, 1'b0);
        check_output("done_tms", tms, 1'b0);
        rises = 0;
      end
    end
    prev_tck = tck;
  end

  task automatic apply_stimulus(input logic [1:0] op, input int len, input logic [37:0] data,
                                output int lat);
    int n;
    expect_cmd(op, len, data);
    @(posedge clk); #1;
    n = 0;
    while (!cmd_ready && n < 5000) begin @(posedge clk); #1; n++; end
    cmd_op = op; cmd_len = len[5:0]; cmd_data = data; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_op = ~op; cmd_len = ~len[5:0]; cmd_data = ~data;
    n = 1;
    while (!rsp_valid && n < 5000) begin @(posedge clk); #1; n++; end
    lat = n;
    check_output("rsp_timeout", rsp_valid, 1'b1);
    @(posedge clk); #1;
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat, r0, c0, n;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_tck", tck, 1'b0);
    check_output("reset_tms", tms, 1'b1);
    check_output("reset_tdi", tdi, 1'b0);
    check_output("reset_ready", cmd_ready, 1'b1);
    check_output("reset_busy", busy, 1'b0);
    check_output("reset_rsp_valid", rsp_valid, 1'b0);
    @(negedge clk); #2 reset_n = 1'b1;

    // TAP reset
    r0 = total_rises; c0 = rsp_count;
    apply_stimulus(2'd2, 0, 38'h0, lat);
    check_output("trst_tcks", total_rises - r0, 6 + RTI_EXTRA);
    check_output("trst_rsp_once", rsp_count - c0, 1);
    check_output("trst_tap_rti", tap_st, T_RTI);
    check_output("trst_rsp_data", last_rsp, 38'h0);

    // Full-width DR scan
    r0 = total_rises;
    apply_stimulus(2'd0, 38, 38'h15_1234_5678, lat);
    check_output("dr38_tcks", total_rises - r0, 43 + RTI_EXTRA);
    check_output("dr38_rsp", last_rsp, 38'h2A_5A5A_A5A5);
    check_output("dr38_tap_dr", dr_upd, 38'h15_1234_5678);
    check_output("dr38_tap_rti", tap_st, T_RTI);

    // IR scan
    r0 = total_rises;
    apply_stimulus(2'd1, 2, 38'b10, lat);
    check_output("ir_tcks", total_rises - r0, 8 + RTI_EXTRA);
    check_output("ir_rsp", last_rsp, 38'b01);
    check_output("ir_tap_ir", ir_upd, 2'b10);

    // Shortest and a short DR scan
    r0 = total_rises;
    apply_stimulus(2'd0, 1, 38'h0, lat);
    check_output("dr1_tcks", total_rises - r0, 6 + RTI_EXTRA);
    check_output("dr1_rsp", last_rsp, 38'h1);
    r0 = total_rises;
    apply_stimulus(2'd0, 4, 38'hA, lat);
    check_output("dr4_tcks", total_rises - r0, 9 + RTI_EXTRA);
    check_output("dr4_rsp", last_rsp, 38'h5);

    // Rejected commands
    r0 = total_rises;
    apply_stimulus(2'd0, 0, 38'h3, lat);
    check_output("len0_latency_ok", lat <= 2, 1'b1);
    check_output("len0_err", last_err, 1'b1);
    apply_stimulus(2'd1, 39, 38'h3, lat);
    check_output("len39_latency_ok", lat <= 2, 1'b1);
    check_output("len39_err", last_err, 1'b1);
    apply_stimulus(2'd3, 5, 38'h3, lat);
    check_output("op3_latency_ok", lat <= 2, 1'b1);
    check_output("op3_err", last_err, 1'b1);
    check_output("err_no_tck", total_rises - r0, 0);

    // Back-to-back with cmd_valid held high
    expect_cmd(2'd0, 38, 38'h0F_0F0F_0F0F);
    expect_cmd(2'd1, 2, 38'b01);
    c0 = rsp_count;
    @(posedge clk); #1;
    cmd_op = 2'd0; cmd_len = 6'd38; cmd_data = 38'h0F_0F0F_0F0F; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_op = 2'd1; cmd_len = 6'd2; cmd_data = 38'b01;
    n = 0;
    while (!cmd_ready && n < 5000) begin @(posedge clk); #1; n++; end
    check_output("b2b_ready_after_rsp", rsp_count - c0, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 5000) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    check_output("b2b_rsp_count", rsp_count - c0, 2);
    check_output("b2b_tap_dr", dr_upd, 38'h0F_0F0F_0F0F);
    check_output("b2b_tap_ir", ir_upd, 2'b01);

    // Reset in the middle of a DR shift
    expect_cmd(2'd0, 38, 38'h3F_FFFF_0000);
    r0 = total_rises; c0 = rsp_count;
    @(posedge clk); #1;
    cmd_op = 2'd0; cmd_len = 6'd38; cmd_data = 38'h3F_FFFF_0000; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    n = 0;
    while (total_rises < r0 + 10 && n < 2000) begin @(posedge clk); #1; n++; end
    check_output("mid_shift_reached", total_rises >= r0 + 10, 1'b1);
    @(negedge clk); #2 reset_n = 1'b0;
    #1;
    check_output("abort_tck", tck, 1'b0);
    check_output("abort_tms", tms, 1'b1);
    check_output("abort_tdi", tdi, 1'b0);
    check_output("abort_ready", cmd_ready, 1'b1);
    check_output("abort_busy", busy, 1'b0);
    check_output("abort_rsp_valid", rsp_valid, 1'b0);
    check_output("abort_rsp_err", rsp_err, 1'b0);
    check_output("abort_rsp_data", rsp_data, 38'h0);
    exp_tck_q.delete();
    exp_rsp_q.delete();
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      check_output("post_reset_tck", tck, 1'b0);
      check_output("post_reset_ready", cmd_ready, 1'b1);
    end
    check_output("abort_no_rsp", rsp_count - c0, 0);

    // Resynchronise the target and scan again
    apply_stimulus(2'd2, 0, 38'h0, lat);
    check_output("resync_tap_rti", tap_st, T_RTI);
    apply_stimulus(2'd0, 38, 38'h2B_DEAD_BEEF, lat);
    check_output("resync_rsp", last_rsp, 38'h2A_5A5A_A5A5);
    check_output("resync_tap_dr", dr_upd, 38'h2B_DEAD_BEEF);

    repeat (4) @(posedge clk);
    check_output("leftover_tck_exp", exp_tck_q.size(), 0);
    check_output("leftover_rsp_exp", exp_rsp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
